// File: rtl/pll_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_pkg
//  Description : Shared types and constants for the software PLL acquisition
//                sequencer: state encoding, VCO word width, default timing
//                constants and the seed clamp helper.
//  Revision    : 1.0  initial release
// ============================================================================
package pll_pkg;

   // VCO frequency word width and raw edge-count width (one extra bit so an
   // out-of-range measurement is visible to the clamp before truncation).
   localparam int VCO_W = 10;
   localparam int CNT_W = 11;

   // Defaults shared with the PLL top level.
   localparam int DEF_GATE_LOG2    = 16;
   localparam int DEF_NOSIG_CYCLES = 2000;
   localparam int DEF_WIN_LOG2     = 16;
   localparam int DEF_LOCK_ERR_MAX = 1024;
   localparam int DEF_LOCK_WINS    = 4;

   // Encoding is visible on the LED port, so the values are fixed.
   typedef enum logic [2:0] {
      ST_NOSIG   = 3'd0,
      ST_MEASURE = 3'd1,
      ST_SEED    = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_TRACK   = 3'd4,
      ST_LOCKED  = 3'd5
   } pll_state_e;

   // Clamp a raw edge count into [lo, hi]. An inverted range (lo > hi) is
   // not meaningful; it resolves to hi so the result is always deterministic.
   function automatic logic [VCO_W-1:0] clamp_seed(
      input logic [CNT_W-1:0] cnt,
      input logic [VCO_W-1:0] lo,
      input logic [VCO_W-1:0] hi
   );
      logic [VCO_W-1:0] res;
      if (lo > hi)
         res = hi;
      else if (cnt > {1'b0, hi})
         res = hi;
      else if (cnt < {1'b0, lo})
         res = lo;
      else
         res = cnt[VCO_W-1:0];
      return res;
   endfunction

endpackage : pll_pkg
`default_nettype wire

// File: rtl/pll_acq_ctrl_edge_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pll_edge_meter
//  Description : Frequency gate. Counts feedback rising edges over exactly
//                2^GATE_LOG2 cycles following a clear, with a saturating
//                11-bit edge counter.
//  Ports       : clk_50   - clock
//                rst      - synchronous active-high reset
//                clear_i  - holds both counters at zero (gate restarts the
//                           cycle after clear drops)
//                rise_i   - rising edge seen this cycle
//                count_o  - edge count including this cycle's edge
//                done_o   - this cycle is the last gate cycle
//  Revision    : 1.0  initial release
// ============================================================================
module pll_edge_meter
   import pll_pkg::*;
#(
   parameter int GATE_LOG2 = DEF_GATE_LOG2
) (
   input  logic             clk_50,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             rise_i,
   output logic [CNT_W-1:0] count_o,
   output logic             done_o
);

   logic [GATE_LOG2-1:0] gate_q, gate_d;
   logic [CNT_W-1:0]     edges_q, edges_d;

   always_comb begin
      gate_d  = gate_q + 1'b1;
      edges_d = edges_q;
      if (rise_i && (edges_q != '1))
         edges_d = edges_q + 1'b1;
   end

   always_ff @(posedge clk_50) begin
      if (rst || clear_i) begin
         gate_q  <= '0;
         edges_q <= '0;
      end else begin
         gate_q  <= gate_d;
         edges_q <= edges_d;
      end
   end

   // The count is taken from the next-state value so that an edge landing on
   // the final gate cycle is part of the result.
   assign count_o = edges_d;
   assign done_o  = (gate_q == '1) && !clear_i;

endmodule : pll_edge_meter
`default_nettype wire

// File: rtl/pll_acq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pll_acq_ctrl
//  Description : PLL acquisition sequencer. Detects feedback activity,
//                measures the feedback frequency in VCO-word units, seeds the
//                VCO frequency register, enables the loop filter and declares
//                lock from phase-comparator slew activity.
//  Ports       : clk_50    - sole clock
//                rst       - synchronous active-high reset
//                fb        - synchronized feedback input
//                slew_fast - comparator speed-up request
//                slew_slow - comparator slow-down request
//                start     - reacquire request (level or pulse)
//                freq_min  - lower seed bound
//                freq_max  - upper seed bound
//                freq_seed - measured, clamped VCO word
//                freq_load - one-cycle VCO register load strobe
//                loop_en   - loop-filter update enable
//                locked    - lock indicator
//                state     - current state (LEDs)
//  Revision    : 1.0  initial release
// ============================================================================
module pll_acq_ctrl
   import pll_pkg::*;
#(
   parameter int GATE_LOG2    = DEF_GATE_LOG2,
   parameter int NOSIG_CYCLES = DEF_NOSIG_CYCLES,
   parameter int WIN_LOG2     = DEF_WIN_LOG2,
   parameter int LOCK_ERR_MAX = DEF_LOCK_ERR_MAX,
   parameter int LOCK_WINS    = DEF_LOCK_WINS
) (
   input  logic             clk_50,
   input  logic             rst,
   input  logic             fb,
   input  logic             slew_fast,
   input  logic             slew_slow,
   input  logic             start,
   input  logic [VCO_W-1:0] freq_min,
   input  logic [VCO_W-1:0] freq_max,
   output logic [VCO_W-1:0] freq_seed,
   output logic             freq_load,
   output logic             loop_en,
   output logic             locked,
   output logic [2:0]       state
);

   localparam int IDLE_W = $clog2(NOSIG_CYCLES + 1);
   localparam int GW_W   = $clog2(LOCK_WINS + 1);

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   pll_state_e           state_q;
   logic [VCO_W-1:0]     seed_q;
   logic [GW_W-1:0]      good_q;
   logic                 fb_d_q;
   logic [IDLE_W-1:0]    idle_q, idle_d;
   logic [WIN_LOG2-1:0]  win_q, win_d;
   logic [WIN_LOG2-1:0]  err_q, err_d;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic                 fb_toggle;
   logic                 fb_rise;
   logic                 nosig;
   logic                 loop_active;
   logic                 tracking;
   logic                 win_end;
   logic [WIN_LOG2-1:0]  err_total;
   logic                 win_good;
   logic [GW_W-1:0]      good_d;
   logic                 meas_clear;
   logic [CNT_W-1:0]     meas_count;
   logic                 meas_done;

   assign fb_toggle   = fb ^ fb_d_q;
   assign fb_rise     = fb & ~fb_d_q;
   assign nosig       = (idle_q == IDLE_W'(NOSIG_CYCLES));
   assign loop_active = (state_q == ST_SETTLE) || (state_q == ST_TRACK) ||
                        (state_q == ST_LOCKED);
   assign tracking    = (state_q == ST_TRACK) || (state_q == ST_LOCKED);
   assign win_end     = (win_q == '1);

   // A start request always restarts the gate: either we are about to enter
   // MEASURE from another state, or MEASURE is being restarted in place.
   assign meas_clear  = (state_q != ST_MEASURE) || start;

   always_comb begin
      // Idle counter: cleared by any fb transition, saturates at the limit.
      idle_d = idle_q;
      if (fb_toggle)
         idle_d = '0;
      else if (!nosig)
         idle_d = idle_q + 1'b1;

      // Window counter only runs while the loop is enabled; it is zero on
      // SETTLE entry because SEED always precedes SETTLE.
      win_d = loop_active ? win_q + 1'b1 : '0;

      // Slew-activity total for the current window, including this cycle.
      err_total = err_q;
      if ((slew_fast || slew_slow) && (err_q != '1))
         err_total = err_q + 1'b1;

      err_d = (tracking && !win_end) ? err_total : '0;
   end

   assign win_good = (int'(err_total) <= LOCK_ERR_MAX);

   // Good-window run length; held at LOCK_WINS once reached so a long lock
   // cannot wrap the counter.
   always_comb begin
      good_d = '0;
      if (win_good)
         good_d = (good_q == GW_W'(LOCK_WINS)) ? good_q : good_q + 1'b1;
   end

   // ------------------------------------------------------------------------
   // Frequency gate
   // ------------------------------------------------------------------------
   pll_edge_meter #(
      .GATE_LOG2 (GATE_LOG2)
   ) u_meter (
      .clk_50  (clk_50),
      .rst     (rst),
      .clear_i (meas_clear),
      .rise_i  (fb_rise),
      .count_o (meas_count),
      .done_o  (meas_done)
   );

   // ------------------------------------------------------------------------
   // Activity detector and window counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_50) begin
      if (rst) begin
         fb_d_q <= 1'b0;
         idle_q <= '0;
         win_q  <= '0;
         err_q  <= '0;
      end else begin
         fb_d_q <= fb;
         idle_q <= idle_d;
         win_q  <= win_d;
         err_q  <= err_d;
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------------
   // In NOSIG the idle counter is still saturated on the cycle the first
   // transition arrives, so the NOSIG exit is checked ahead of the nosig
   // override; otherwise MEASURE would start one cycle late.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         state_q <= ST_NOSIG;
         seed_q  <= '0;
         good_q  <= '0;
      end else if (state_q == ST_NOSIG) begin
         if (fb_toggle)
            state_q <= ST_MEASURE;
      end else if (nosig) begin
         state_q <= ST_NOSIG;
      end else if (start) begin
         state_q <= ST_MEASURE;
      end else begin
         case (state_q)
            ST_MEASURE: begin
               if (meas_done) begin
                  seed_q  <= clamp_seed(meas_count, freq_min, freq_max);
                  state_q <= ST_SEED;
               end
            end
            ST_SEED: begin
               state_q <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (win_end) begin
                  good_q  <= '0;
                  state_q <= ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (win_end) begin
                  good_q <= good_d;
                  if (good_d == GW_W'(LOCK_WINS))
                     state_q <= ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (win_end) begin
                  good_q <= good_d;
                  if (!win_good)
                     state_q <= ST_TRACK;
               end
            end
            default: begin
               state_q <= ST_NOSIG;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs, decoded from registered state
   // ------------------------------------------------------------------------
   assign freq_seed = seed_q;
   assign freq_load = (state_q == ST_SEED);
   assign loop_en   = loop_active;
   assign locked    = (state_q == ST_LOCKED);
   assign state     = state_q;

endmodule : pll_acq_ctrl
`default_nettype wire

// File: tb/tb_pll_acq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_acq_ctrl
//  Description : Self-checking bench for pll_acq_ctrl with shortened gate,
//                window and idle constants. Table of fb periods / seed bounds
//                with hand-computed seeds and latencies, followed by directed
//                sequences for lock loss, restart, signal loss, reset and the
//                last-gate-cycle edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pll_acq_ctrl;

   localparam int GATE_LOG2    = 10;    // 1024-cycle gate
   localparam int NOSIG_CYCLES = 1200;
   localparam int WIN_LOG2     = 8;     // 256-cycle windows
   localparam int LOCK_ERR_MAX = 16;
   localparam int LOCK_WINS    = 4;

   localparam int GATE = 1 << GATE_LOG2;
   localparam int WIN  = 1 << WIN_LOG2;

   logic       clk_50 = 1'b0;
   logic       rst = 1'b1;
   logic       fb = 1'b0;
   logic       slew_fast = 1'b0;
   logic       slew_slow = 1'b0;
   logic       start = 1'b0;
   logic [9:0] freq_min = 10'd0;
   logic [9:0] freq_max = 10'd0;
   logic [9:0] freq_seed;
   logic       freq_load;
   logic       loop_en;
   logic       locked;
   logic [2:0] state;

   pll_acq_ctrl #(
      .GATE_LOG2    (GATE_LOG2),
      .NOSIG_CYCLES (NOSIG_CYCLES),
      .WIN_LOG2     (WIN_LOG2),
      .LOCK_ERR_MAX (LOCK_ERR_MAX),
      .LOCK_WINS    (LOCK_WINS)
   ) dut (
      .clk_50    (clk_50),
      .rst       (rst),
      .fb        (fb),
      .slew_fast (slew_fast),
      .slew_slow (slew_slow),
      .start     (start),
      .freq_min  (freq_min),
      .freq_max  (freq_max),
      .freq_seed (freq_seed),
      .freq_load (freq_load),
      .loop_en   (loop_en),
      .locked    (locked),
      .state     (state)
   );

   always #5 clk_50 = ~clk_50;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_chg = 0;
   bit gen_on = 1'b0;
   int per = 8;
   int ph = 0;

   typedef struct {
      int per;
      int fmin;
      int fmax;
      int exp_seed;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: outputs are settled #1 after the edge; inputs changed here
   // are sampled at the next edge. The square-wave generator advances here.
   task automatic step();
      logic nv;
      @(posedge clk_50);
      #1;
      cyc++;
      if (gen_on) begin
         ph = (ph + 1) % per;
         nv = (ph >= per / 2);
         if (nv != fb) begin
            fb = nv;
            last_chg = cyc;
         end
      end
   endtask

   // Arm the generator so that its first update produces an fb transition.
   task automatic start_gen(input int p);
      per = p;
      ph  = (fb == 1'b0) ? (p / 2 - 1) : (p - 1);
      gen_on = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      gen_on = 1'b0;
      fb = 1'b0;
      start = 1'b0;
      slew_fast = 1'b0;
      slew_slow = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_load(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!freq_load && n < GATE + 100);
   endtask

   task automatic wait_lock(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!locked && n < 6 * WIN + 100);
   endtask

   initial begin
      int n;
      int loads;
      int prevl;
      int guard;

      // period, freq_min, freq_max, expected seed (edges = GATE / period)
      vecs[0] = '{per: 8,  fmin: 20,  fmax: 300, exp_seed: 128}; // in range
      vecs[1] = '{per: 64, fmin: 20,  fmax: 300, exp_seed: 20};  // 16 -> min
      vecs[2] = '{per: 2,  fmin: 20,  fmax: 300, exp_seed: 300}; // 512 -> max
      vecs[3] = '{per: 16, fmin: 64,  fmax: 300, exp_seed: 64};  // equals min
      vecs[4] = '{per: 8,  fmin: 200, fmax: 100, exp_seed: 100}; // min > max
      vecs[5] = '{per: 4,  fmin: 20,  fmax: 256, exp_seed: 256}; // equals max

      // ---------------- reset state ----------------
      do_reset();
      chk("rst_state", int'(state), 0);
      chk("rst_seed", int'(freq_seed), 0);
      chk("rst_outs", int'({freq_load, loop_en, locked}), 0);

      // ---------------- table-driven acquisitions ----------------
      for (int i = 0; i < 6; i++) begin
         do_reset();
         freq_min = 10'(vecs[i].fmin);
         freq_max = 10'(vecs[i].fmax);
         start_gen(vecs[i].per);
         step();                    // fb rises; next edge samples it (T)
         wait_load(n);
         chk($sformatf("v%0d_load_lat", i), n, GATE + 1);
         chk($sformatf("v%0d_seed", i), int'(freq_seed), vecs[i].exp_seed);
         chk($sformatf("v%0d_seed_state", i), int'(state), 2);
         step();
         chk($sformatf("v%0d_loop_en_rise", i), int'({loop_en, freq_load}), 2);
         wait_lock(n);
         chk($sformatf("v%0d_lock_lat", i), n, (1 + LOCK_WINS) * WIN);
      end

      // ---------------- bad window while LOCKED ----------------
      slew_fast = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (locked && n < 2 * WIN);
      chk("bad_win_lat", n, WIN);
      chk("bad_win_state", int'(state), 4);
      chk("bad_win_loop_en", int'(loop_en), 1);

      // Exactly LOCK_ERR_MAX slew cycles still counts as a good window.
      slew_fast = 1'b0;
      slew_slow = 1'b1;
      repeat (LOCK_ERR_MAX) step();
      slew_slow = 1'b0;
      wait_lock(n);
      chk("errmax_window_lock_lat", n + LOCK_ERR_MAX, LOCK_WINS * WIN);

      // ---------------- start pulse in LOCKED ----------------
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_state", int'(state), 1);
      chk("restart_outs", int'({loop_en, locked}), 0);
      wait_load(n);
      chk("restart_load_lat", n, GATE);
      chk("restart_seed", int'(freq_seed), 256);

      // ---------------- held start ----------------
      start = 1'b1;
      loads = 0;
      repeat (GATE + 500) begin
         step();
         if (freq_load) loads++;
      end
      chk("held_start_loads", loads, 0);
      chk("held_start_state", int'(state), 1);
      start = 1'b0;
      wait_load(n);
      chk("release_load_lat", n, GATE);
      wait_lock(n);
      chk("release_lock_lat", n, 1 + (1 + LOCK_WINS) * WIN);

      // ---------------- loss of signal while LOCKED ----------------
      gen_on = 1'b0;
      n = 0;
      prevl = 0;
      do begin
         prevl = int'(locked);
         step();
         n++;
      end while (state != 3'd0 && n < NOSIG_CYCLES + 200);
      chk("nosig_prev_locked", prevl, 1);
      chk("nosig_lat", cyc - last_chg, NOSIG_CYCLES + 2);
      chk("nosig_outs", int'({loop_en, locked}), 0);

      // Toggling resumes -> MEASURE one cycle after the transition is sampled.
      start_gen(8);
      step();
      chk("resume_still_nosig", int'(state), 0);
      step();
      chk("resume_measure", int'(state), 1);

      // ---------------- nosig and start together ----------------
      gen_on = 1'b0;
      guard = 0;
      while ((cyc - last_chg) < NOSIG_CYCLES + 1 && guard < NOSIG_CYCLES + 50) begin
         step();
         guard++;
      end
      chk("pre_nosig_active", int'(state != 3'd0), 1);
      start = 1'b1;
      step();
      chk("nosig_beats_start", int'(state), 0);
      step();
      chk("start_ignored_in_nosig", int'(state), 0);
      start = 1'b0;

      // ---------------- reset mid-MEASURE ----------------
      freq_min = 10'd20;
      freq_max = 10'd256;
      start_gen(8);
      step();
      step();
      repeat (500) step();
      chk("mid_measure_state", int'(state), 1);
      rst = 1'b1;
      gen_on = 1'b0;
      fb = 1'b0;
      step();
      chk("rst_mid_state", int'(state), 0);
      chk("rst_mid_seed", int'(freq_seed), 0);
      chk("rst_mid_outs", int'({freq_load, loop_en, locked}), 0);
      rst = 1'b0;
      loads = 0;
      repeat (GATE + 100) begin
         step();
         if (freq_load) loads++;
      end
      chk("rst_mid_no_load", loads, 0);

      // ---------------- rising edge on the last gate cycle ----------------
      do_reset();
      freq_min = 10'd0;
      freq_max = 10'd1023;
      fb = 1'b1;
      step();                    // transition sampled; MEASURE from here
      fb = 1'b0;                 // gate cycle 0 sees a fall only
      repeat (GATE - 1) step();
      fb = 1'b1;                 // rise during gate cycle GATE-1
      step();
      chk("last_gate_load", int'(freq_load), 1);
      chk("last_gate_seed", int'(freq_seed), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule : tb_pll_acq_ctrl
`default_nettype wire

// File: doc/pll_acq_ctrl.md
# pll_acq_ctrl

Acquisition sequencer for the software PLL running on `clk_50`. It watches the synchronized feedback input and measures its frequency directly in VCO-word units. It then seeds the VCO frequency register, enables the loop filter, and declares lock from phase-comparator slew activity. It sits beside the VCO/phase-comparator datapath and replaces the bare no-signal lockout with a full measure/seed/track sequence.

## Interface
- `GATE_LOG2`, 16: measurement gate is 2^GATE_LOG2 cycles. At 16, the edge count equals the VCO word (f·65536/50 MHz).
- `NOSIG_CYCLES`, 2000: cycles without an `fb` transition before signal is declared lost.
- `WIN_LOG2`, 16: settle and lock-evaluation window is 2^WIN_LOG2 cycles.
- `LOCK_ERR_MAX`, 1024: maximum slew-active cycles per window for a window to count as good.
- `LOCK_WINS`, 4: consecutive good windows required to assert lock.

Ports:
- `clk_50` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `fb` in 1: feedback input, already two-flop synchronized.
- `slew_fast` in 1: phase-comparator "speed up" output.
- `slew_slow` in 1: phase-comparator "slow down" output.
- `start` in 1: reacquire request (level or pulse).
- `freq_min` in 10: lower bound for the seed.
- `freq_max` in 10: upper bound for the seed.
- `freq_seed` out 10: measured, clamped VCO word.
- `freq_load` out 1: one-cycle load strobe for the VCO frequency register.
- `loop_en` out 1: permits loop-filter frequency updates.
- `locked` out 1: lock indicator.
- `state` out 3: current state, for LEDs.

## Operation
- States and encoding: NOSIG=0, MEASURE=1, SEED=2, SETTLE=3, TRACK=4, LOCKED=5.
- Activity detector:
  - `fb_d` holds `fb` delayed one cycle.
  - `idle_cnt` clears on `fb ^ fb_d` and otherwise increments, saturating at NOSIG_CYCLES.
  - `nosig = (idle_cnt == NOSIG_CYCLES)`.
- Transition priority, highest first:
  1. `rst`
  2. `nosig` forces NOSIG from any state.
  3. `start` forces MEASURE from any state except NOSIG.
  4. Per-state rules below.
- NOSIG: go to MEASURE on the first `fb` transition.
- MEASURE:
  - The gate counter and 11-bit edge counter clear on entry.
  - Count `fb` rising edges (`fb & ~fb_d`) over exactly 2^GATE_LOG2 cycles, starting with the first cycle in MEASURE.
  - The edge counter saturates at 2047.
  - A rising edge on the last gate cycle is counted.
  - At gate end, register `freq_seed = clamp(count, freq_min, freq_max)` and go to SEED.
- SEED: lasts one cycle, then goes to SETTLE.
- SETTLE: wait 2^WIN_LOG2 cycles, then go to TRACK with `good_wins = 0`.
- TRACK and LOCKED, per window of 2^WIN_LOG2 cycles:
  - `err_cnt` counts cycles with `slew_fast | slew_slow`, saturating at 2^WIN_LOG2−1.
  - At window end: if `err_cnt ≤ LOCK_ERR_MAX`, increment `good_wins`; otherwise clear it.
  - `err_cnt` clears for the next window.
  - TRACK goes to LOCKED when `good_wins` reaches LOCK_WINS.
  - LOCKED goes to TRACK (with `good_wins = 0`) on one bad window.
- Outputs decode from the registered state:
  - `freq_load = (state == SEED)`.
  - `loop_en = state ∈ {SETTLE, TRACK, LOCKED}`.
  - `locked = (state == LOCKED)`.
- `freq_seed` holds its value until the next MEASURE end.
- `freq_min > freq_max` is unsupported; in that case the result is `freq_max`.

## Timing
- Reset values:
  - State: NOSIG.
  - Outputs: `freq_seed = 0`, `freq_load = 0`, `loop_en = 0`, `locked = 0`, `state = 0`.
  - Internal: all counters 0, `fb_d = 0`.
- Start of measurement: an `fb` transition sampled in cycle T (while in NOSIG) puts MEASURE in effect at T+1.
- Seed load: `freq_load` is high exactly at cycle T+1+2^GATE_LOG2. `freq_seed` is valid in that same cycle.
- Loop enable: `loop_en` rises at T+2+2^GATE_LOG2.
- Earliest lock: `locked` rises at T+2+2^GATE_LOG2 + (1+LOCK_WINS)·2^WIN_LOG2.
- Loss of signal:
  - `nosig` asserts NOSIG_CYCLES cycles after the last transition.
  - State becomes NOSIG, and `loop_en` and `locked` fall, on the next cycle.
- Held `start`: MEASURE restarts every cycle, so no seed is produced until `start` is released.
- Reset mid-operation: any `rst` cycle returns the block to its reset state on the next edge; no partial `freq_load` is produced.

## Structure
- Shared package `pll_pkg`:
  - State enum.
  - VCO word width (10).
  - Default parameter constants, shared with the PLL top.
- Sub-module `pll_edge_meter`: gate counter plus saturating edge counter, with `clear` and `done` ports. The controller holds the FSM, activity detector and lock windows.

## Test plan
- 125 kHz `fb` (square wave, 400-cycle period), `freq_min = 65`, `freq_max = 524` → `freq_seed` ∈ {163, 164}, one-cycle `freq_load` at T+65537, `loop_en` rises one cycle later.
- 20 kHz `fb` → raw count 26 → `freq_seed = 65`. 500 kHz `fb` → raw count 655 → `freq_seed = 524`.
- `slew_*` tied 0 after SEED → `locked` rises exactly 5·65536 cycles after `loop_en`. One window with 2000 slew cycles while LOCKED → `locked` falls at that window end and state = TRACK.
- `fb` frozen for 2000 cycles while LOCKED → state NOSIG; `loop_en` and `locked` drop the following cycle. Toggling resumes → MEASURE.
- `rst` asserted mid-MEASURE → all outputs at reset values next cycle and no `freq_load`. `start` pulse in LOCKED → MEASURE, `loop_en = 0`, then a fresh seed.
- `fb` rising edge on the last gate cycle → that edge is included in the count. Simultaneous `nosig` and `start` → NOSIG.
